// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared control-bit indices, FSM state and tag types for alu_issue_arb
package alu_arb_pkg;

    localparam int ALU_ADD = 0;
    localparam int ALU_LD  = 1;
    localparam int ALU_ST  = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_MUL = 4;
    localparam int ALU_CMP = 5;
    localparam int ALU_MOV = 6;
    localparam int ALU_OR  = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_NOT = 9;
    localparam int ALU_LSL = 10;
    localparam int ALU_LSR = 11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_HOLD = 1'b1
    } arb_state_e;

    typedef logic lane_t;

    typedef struct packed {
        logic        valid;
        lane_t       lane;
        logic [15:0] instr;
    } arb_tag_t;

endpackage

// File: rtl/alu_issue_arb_if.sv
// rtl/alu_issue_arb_if.sv - one dispatch lane's valid/ready request into alu_issue_arb
interface alu_issue_arb_if;
    logic        valid;
    logic        ready;
    logic [11:0] alusignals;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  immx;
    logic        isimm;
    logic [15:0] instr;

    modport master (output valid, alusignals, op1, op2, immx, isimm, instr, input ready);
    modport slave  (input valid, alusignals, op1, op2, immx, isimm, instr, output ready);
endinterface

// File: rtl/alu_arb_tag_pipe.sv
// rtl/alu_arb_tag_pipe.sv - DEPTH-stage tag delay line with synchronous clear
module alu_arb_tag_pipe
    import alu_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr_i,
    input  arb_tag_t tag_i,
    output arb_tag_t tag_o,
    output logic     any_valid_o
);
    arb_tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid_o = any_valid_o | stage_q[i].valid;
    end
endmodule

// File: rtl/alu_issue_arb.sv
// rtl/alu_issue_arb.sv - dual-lane ALU issue arbiter with multiply hold and result tag tracking
// Build option ALU_ARB_FIXED_PRIO_EN: lane 0 always wins contention (no last-grant pointer).
module alu_issue_arb
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 2,
    parameter int MUL_GAP = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_issue_arb_if.slave req0,
    alu_issue_arb_if.slave req1,
    output logic [11:0]    alu_alusignals,
    output logic [15:0]    alu_op1,
    output logic [15:0]    alu_op2,
    output logic [4:0]     alu_immx,
    output logic           alu_isimm,
    output logic [15:0]    alu_instr,
    output logic           res_valid,
    output logic           res_lane,
    output logic [15:0]    res_instr,
    output logic           busy
);
    localparam logic [0:0] IDLE     = ST_IDLE;
    localparam logic [0:0] MUL_HOLD = ST_MUL_HOLD;
    localparam int CNT_W = (MUL_GAP > 2) ? $clog2(MUL_GAP) : 1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lane_t            sel;
    logic             can_issue, hs;

    logic [11:0] f_sig;
    logic [15:0] f_op1, f_op2, f_instr;
    logic [4:0]  f_immx;
    logic        f_isimm;

    logic        iss_vld_q, iss_vld_d;
    lane_t       iss_lane_q, iss_lane_d;
    logic [11:0] iss_sig_q, iss_sig_d;
    logic [15:0] iss_op1_q, iss_op1_d, iss_op2_q, iss_op2_d, iss_instr_q, iss_instr_d;
    logic [4:0]  iss_immx_q, iss_immx_d;
    logic        iss_isimm_q, iss_isimm_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign sel = !req0.valid;
`else
    lane_t last_q, last_d;

    always_comb begin
        sel = !req0.valid;
        if (req0.valid && req1.valid) sel = ~last_q;
    end

    assign last_d = hs ? sel : last_q;

    // Reset points at lane 1 so lane 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
`endif

    assign can_issue  = (state_q == IDLE) && !flush && !rst;
    assign req0.ready = can_issue && req0.valid && !sel;
    assign req1.ready = can_issue && req1.valid && sel;
    assign hs         = req0.ready || req1.ready;

    always_comb begin
        if (sel) begin
            f_sig = req1.alusignals; f_op1 = req1.op1; f_op2 = req1.op2;
            f_immx = req1.immx; f_isimm = req1.isimm; f_instr = req1.instr;
        end else begin
            f_sig = req0.alusignals; f_op1 = req0.op1; f_op2 = req0.op2;
            f_immx = req0.immx; f_isimm = req0.isimm; f_instr = req0.instr;
        end
    end

    // Non-handshake cycles present an all-zero bubble to the ALU.
    always_comb begin
        iss_vld_d   = hs;
        iss_lane_d  = hs ? sel : 1'b0;
        iss_sig_d   = hs ? f_sig : '0;
        iss_op1_d   = hs ? f_op1 : '0;
        iss_op2_d   = hs ? f_op2 : '0;
        iss_immx_d  = hs ? f_immx : '0;
        iss_isimm_d = hs ? f_isimm : 1'b0;
        iss_instr_d = hs ? f_instr : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == MUL_HOLD) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (hs && f_sig[ALU_MUL] && (MUL_GAP > 1)) begin
            state_d = MUL_HOLD;
            cnt_d   = CNT_W'(MUL_GAP - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            iss_vld_q   <= 1'b0;
            iss_lane_q  <= 1'b0;
            iss_sig_q   <= '0;
            iss_op1_q   <= '0;
            iss_op2_q   <= '0;
            iss_immx_q  <= '0;
            iss_isimm_q <= 1'b0;
            iss_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iss_vld_q   <= iss_vld_d;
            iss_lane_q  <= iss_lane_d;
            iss_sig_q   <= iss_sig_d;
            iss_op1_q   <= iss_op1_d;
            iss_op2_q   <= iss_op2_d;
            iss_immx_q  <= iss_immx_d;
            iss_isimm_q <= iss_isimm_d;
            iss_instr_q <= iss_instr_d;
        end
    end

    assign alu_alusignals = iss_sig_q;
    assign alu_op1        = iss_op1_q;
    assign alu_op2        = iss_op2_q;
    assign alu_immx       = iss_immx_q;
    assign alu_isimm      = iss_isimm_q;
    assign alu_instr      = iss_instr_q;

    arb_tag_t iss_tag, res_tag;
    logic     tags_busy;

    assign iss_tag = {iss_vld_q, iss_lane_q, iss_instr_q};

    alu_arb_tag_pipe #(.DEPTH(ALU_LAT)) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (flush),
        .tag_i       (iss_tag),
        .tag_o       (res_tag),
        .any_valid_o (tags_busy)
    );

    assign res_valid = res_tag.valid;
    assign res_lane  = res_tag.lane;
    assign res_instr = res_tag.instr;
    assign busy      = (state_q == MUL_HOLD) || iss_vld_q || tags_busy;
endmodule
